// File: rtl/tcp_tx_hdr_gen_if.sv
// Command and header-descriptor channels between the TCP connection FSM,
// the TCP header generator and the header serializer.
interface tcp_tx_hdr_gen_if;
    logic [2:0]  i_tx_ctrl;
    logic [15:0] i_tx_len;
    logic        i_tx_ctrl_valid;
    logic        o_tx_ctrl_ack;
    logic [31:0] o_seq_number;
    logic [31:0] o_ack_number;
    logic [7:0]  o_flags;
    logic [15:0] o_window_size;
    logic [15:0] o_payload_len;
    logic        o_hdr_valid;
    logic        i_hdr_ready;

    modport master (
        output i_tx_ctrl, i_tx_len, i_tx_ctrl_valid, i_hdr_ready,
        input  o_tx_ctrl_ack, o_seq_number, o_ack_number, o_flags,
               o_window_size, o_payload_len, o_hdr_valid
    );

    modport slave (
        input  i_tx_ctrl, i_tx_len, i_tx_ctrl_valid, i_hdr_ready,
        output o_tx_ctrl_ack, o_seq_number, o_ack_number, o_flags,
               o_window_size, o_payload_len, o_hdr_valid
    );
endinterface

// File: rtl/tcp_tx_hdr_gen.sv
// TCP transmit header generator: queues control commands, tracks SND.NXT and
// emits one header descriptor per command. Optional counters: TCP_TX_HDR_STATS_EN.
module tcp_tx_hdr_gen #(
    parameter int          CMD_DEPTH  = 4,
    parameter logic [31:0] ISN        = 32'h0000_0000,
    parameter logic [15:0] DEF_WINDOW = 16'hFFFF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    tcp_tx_hdr_gen_if.slave    bus,
    input  logic [31:0]        i_rcv_nxt,
    input  logic [15:0]        i_rcv_wnd,
    input  logic               i_rcv_wnd_valid,
    output logic [31:0]        o_snd_nxt,
    output logic               o_err_cmd
`ifdef TCP_TX_HDR_STATS_EN
    ,
    output logic [31:0]        o_stat_hdrs,
    output logic [31:0]        o_stat_bytes,
    output logic [15:0]        o_stat_drops
`endif
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(CMD_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);

    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_SYN    = 3'd1;
    localparam logic [2:0] CMD_SYNACK = 3'd2;
    localparam logic [2:0] CMD_ACK    = 3'd3;
    localparam logic [2:0] CMD_FIN    = 3'd4;
    localparam logic [2:0] CMD_RST    = 3'd5;
    localparam logic [2:0] CMD_DATA   = 3'd6;
    localparam logic [2:0] CMD_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUILD   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t           state_r;
    logic [18:0]      fifo_mem_r [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic [2:0]  cur_cmd_r;
    logic [15:0] cur_len_r;
    logic [31:0] seq_r;
    logic [31:0] ack_r;
    logic [7:0]  flags_r;
    logic [15:0] window_r;
    logic [15:0] pay_len_r;
    logic        hdr_valid_r;
    logic [31:0] snd_nxt_r;
    logic        err_r;

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        cmd_ack_s;
    logic        push_s;
    logic        drop_s;
    logic        pop_s;
    logic        hs_s;
    logic [18:0] head_s;
    logic [7:0]  flags_s;
    logic [31:0] ack_num_s;
    logic [15:0] window_s;
    logic [15:0] pay_len_s;
    logic [31:0] adv_s;

    // Accept/queue decisions; NOP and reserved codes are acknowledged but never queued
    always_comb begin
        fifo_full_s  = (count_r == FULL_COUNT);
        fifo_empty_s = (count_r == CNT_ZERO);
        cmd_ack_s    = bus.i_tx_ctrl_valid && !fifo_full_s;
        push_s       = cmd_ack_s && (bus.i_tx_ctrl != CMD_NOP) && (bus.i_tx_ctrl != CMD_RSVD);
        drop_s       = cmd_ack_s && (bus.i_tx_ctrl == CMD_RSVD);
        pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
        hs_s         = (state_r == ST_PRESENT) && hdr_valid_r && bus.i_hdr_ready;
        head_s       = fifo_mem_r[rd_ptr_r];
    end

    // Header field derivation from the command currently being built
    always_comb begin
        flags_s   = 8'h00;
        adv_s     = 32'h0000_0000;
        pay_len_s = 16'h0000;
        case (cur_cmd_r)
            CMD_SYN:    begin flags_s = 8'h02; adv_s = 32'h0000_0001; end
            CMD_SYNACK: begin flags_s = 8'h12; adv_s = 32'h0000_0001; end
            CMD_ACK:    begin flags_s = 8'h10; end
            CMD_FIN:    begin flags_s = 8'h11; adv_s = 32'h0000_0001; end
            CMD_RST:    begin flags_s = 8'h14; end
            CMD_DATA: begin
                // PSH only makes sense when there is payload to push
                if (cur_len_r == 16'h0000) begin
                    flags_s = 8'h10;
                end else begin
                    flags_s = 8'h18;
                end
                adv_s     = {16'h0000, cur_len_r};
                pay_len_s = cur_len_r;
            end
            default: begin
                flags_s   = 8'h00;
                adv_s     = 32'h0000_0000;
                pay_len_s = 16'h0000;
            end
        endcase
        if (cur_cmd_r == CMD_SYN) begin
            ack_num_s = 32'h0000_0000;
        end else begin
            ack_num_s = i_rcv_nxt;
        end
        if (i_rcv_wnd_valid) begin
            window_s = i_rcv_wnd;
        end else begin
            window_s = DEF_WINDOW;
        end
    end

    // Command FIFO storage, pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                fifo_mem_r[i] <= 19'h0_0000;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {bus.i_tx_ctrl, bus.i_tx_len};
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Header FSM: pop, build the descriptor, present it until the serializer takes it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            cur_cmd_r   <= CMD_NOP;
            cur_len_r   <= 16'h0000;
            seq_r       <= 32'h0000_0000;
            ack_r       <= 32'h0000_0000;
            flags_r     <= 8'h00;
            window_r    <= 16'h0000;
            pay_len_r   <= 16'h0000;
            hdr_valid_r <= 1'b0;
            snd_nxt_r   <= ISN;
            err_r       <= 1'b0;
        end else begin
            err_r <= drop_s;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        cur_cmd_r <= head_s[18:16];
                        cur_len_r <= head_s[15:0];
                        state_r   <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    seq_r       <= snd_nxt_r;
                    ack_r       <= ack_num_s;
                    flags_r     <= flags_s;
                    window_r    <= window_s;
                    pay_len_r   <= pay_len_s;
                    hdr_valid_r <= 1'b1;
                    state_r     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (hs_s) begin
                        hdr_valid_r <= 1'b0;
                        snd_nxt_r   <= snd_nxt_r + adv_s;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    hdr_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TCP_TX_HDR_STATS_EN
    logic [31:0] stat_hdrs_r;
    logic [31:0] stat_bytes_r;
    logic [15:0] stat_drops_r;

    // Free-running wrap-around statistics counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_hdrs_r  <= 32'h0000_0000;
            stat_bytes_r <= 32'h0000_0000;
            stat_drops_r <= 16'h0000;
        end else begin
            if (hs_s) begin
                stat_hdrs_r  <= stat_hdrs_r + 32'h0000_0001;
                stat_bytes_r <= stat_bytes_r + {16'h0000, pay_len_r};
            end
            if (drop_s) begin
                stat_drops_r <= stat_drops_r + 16'h0001;
            end
        end
    end

    assign o_stat_hdrs  = stat_hdrs_r;
    assign o_stat_bytes = stat_bytes_r;
    assign o_stat_drops = stat_drops_r;
`endif

    assign bus.o_tx_ctrl_ack = cmd_ack_s;
    assign bus.o_seq_number  = seq_r;
    assign bus.o_ack_number  = ack_r;
    assign bus.o_flags       = flags_r;
    assign bus.o_window_size = window_r;
    assign bus.o_payload_len = pay_len_r;
    assign bus.o_hdr_valid   = hdr_valid_r;
    assign o_snd_nxt         = snd_nxt_r;
    assign o_err_cmd         = err_r;

endmodule

// File: tb/tb_tcp_tx_hdr_gen.sv
// Directed self-checking bench for tcp_tx_hdr_gen: one instance at ISN 0x1000,
// a second at ISN 0xFFFF_FFF0 for sequence wrap-around.
module tb_tcp_tx_hdr_gen;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    tcp_tx_hdr_gen_if a_if ();
    tcp_tx_hdr_gen_if b_if ();

    logic [31:0] rcv_nxt_a, rcv_nxt_b;
    logic [15:0] rcv_wnd_a, rcv_wnd_b;
    logic        wnd_valid_a, wnd_valid_b;
    logic [31:0] snd_nxt_a, snd_nxt_b;
    logic        err_a, err_b;
`ifdef TCP_TX_HDR_STATS_EN
    logic [31:0] st_hdrs_a, st_bytes_a, st_hdrs_b, st_bytes_b;
    logic [15:0] st_drops_a, st_drops_b;
`endif

    int errors = 0;
    int checks = 0;

    tcp_tx_hdr_gen #(.CMD_DEPTH(4), .ISN(32'h0000_1000), .DEF_WINDOW(16'hFFFF)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .bus(a_if),
        .i_rcv_nxt(rcv_nxt_a), .i_rcv_wnd(rcv_wnd_a), .i_rcv_wnd_valid(wnd_valid_a),
        .o_snd_nxt(snd_nxt_a), .o_err_cmd(err_a)
`ifdef TCP_TX_HDR_STATS_EN
        , .o_stat_hdrs(st_hdrs_a), .o_stat_bytes(st_bytes_a), .o_stat_drops(st_drops_a)
`endif
    );

    tcp_tx_hdr_gen #(.CMD_DEPTH(4), .ISN(32'hFFFF_FFF0), .DEF_WINDOW(16'hFFFF)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .bus(b_if),
        .i_rcv_nxt(rcv_nxt_b), .i_rcv_wnd(rcv_wnd_b), .i_rcv_wnd_valid(wnd_valid_b),
        .o_snd_nxt(snd_nxt_b), .o_err_cmd(err_b)
`ifdef TCP_TX_HDR_STATS_EN
        , .o_stat_hdrs(st_hdrs_b), .o_stat_bytes(st_bytes_b), .o_stat_drops(st_drops_b)
`endif
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_hdr_a(output bit found);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (a_if.o_hdr_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        checks++; if (a_if.o_hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %b want 0", a_if.o_hdr_valid); end
        checks++; if (a_if.o_seq_number !== 32'h0) begin errors++; $display("FAIL reset_seq: got %h want 0", a_if.o_seq_number); end
        checks++; if (a_if.o_flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h want 00", a_if.o_flags); end
        checks++; if (a_if.o_window_size !== 16'h0) begin errors++; $display("FAIL reset_window: got %h want 0", a_if.o_window_size); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_a); end
        checks++; if (snd_nxt_a !== 32'h0000_1000) begin errors++; $display("FAIL reset_snd_nxt_a: got %h want 00001000", snd_nxt_a); end
        checks++; if (snd_nxt_b !== 32'hFFFF_FFF0) begin errors++; $display("FAIL reset_snd_nxt_b: got %h want fffffff0", snd_nxt_b); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_syn_latency();
        a_if.i_hdr_ready = 1'b1;
        wnd_valid_a = 1'b0;
        rcv_nxt_a = 32'h1234_5678;
        a_if.i_tx_ctrl = 3'd1; a_if.i_tx_len = 16'd5; a_if.i_tx_ctrl_valid = 1'b1;
        #1;
        checks++; if (a_if.o_tx_ctrl_ack !== 1'b1) begin errors++; $display("FAIL syn_ack: got %b want 1", a_if.o_tx_ctrl_ack); end
        tick();
        a_if.i_tx_ctrl_valid = 1'b0;
        checks++; if (a_if.o_hdr_valid !== 1'b0) begin errors++; $display("FAIL syn_valid_n1: got %b want 0", a_if.o_hdr_valid); end
        tick();
        checks++; if (a_if.o_hdr_valid !== 1'b0) begin errors++; $display("FAIL syn_valid_n2: got %b want 0", a_if.o_hdr_valid); end
        tick();
        checks++; if (a_if.o_hdr_valid !== 1'b1) begin errors++; $display("FAIL syn_valid_n3: got %b want 1", a_if.o_hdr_valid); end
        checks++; if (a_if.o_seq_number !== 32'h0000_1000) begin errors++; $display("FAIL syn_seq: got %h want 00001000", a_if.o_seq_number); end
        checks++; if (a_if.o_ack_number !== 32'h0) begin errors++; $display("FAIL syn_acknum: got %h want 0", a_if.o_ack_number); end
        checks++; if (a_if.o_flags !== 8'h02) begin errors++; $display("FAIL syn_flags: got %h want 02", a_if.o_flags); end
        checks++; if (a_if.o_window_size !== 16'hFFFF) begin errors++; $display("FAIL syn_window: got %h want ffff", a_if.o_window_size); end
        checks++; if (a_if.o_payload_len !== 16'h0) begin errors++; $display("FAIL syn_len: got %h want 0", a_if.o_payload_len); end
        tick();
        checks++; if (a_if.o_hdr_valid !== 1'b0) begin errors++; $display("FAIL syn_valid_after: got %b want 0", a_if.o_hdr_valid); end
        checks++; if (snd_nxt_a !== 32'h0000_1001) begin errors++; $display("FAIL syn_snd_nxt: got %h want 00001001", snd_nxt_a); end
    endtask

    typedef struct {
        logic [2:0]  cmd;
        logic [15:0] len;
        logic [7:0]  flags;
        logic [15:0] plen;
        logic [31:0] seq;
        logic [31:0] snd;
    } vec_t;

    task automatic test_commands();
        vec_t v [4];
        bit found;
        v[0] = '{3'd6, 16'd100, 8'h18, 16'd100, 32'h0000_1001, 32'h0000_1065};
        v[1] = '{3'd6, 16'd0,   8'h10, 16'd0,   32'h0000_1065, 32'h0000_1065};
        v[2] = '{3'd2, 16'd7,   8'h12, 16'd0,   32'h0000_1065, 32'h0000_1066};
        v[3] = '{3'd3, 16'd9,   8'h10, 16'd0,   32'h0000_1066, 32'h0000_1066};
        rcv_nxt_a = 32'hABCD_0001; rcv_wnd_a = 16'h0800; wnd_valid_a = 1'b1;
        a_if.i_hdr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_if.i_tx_ctrl = v[k].cmd; a_if.i_tx_len = v[k].len; a_if.i_tx_ctrl_valid = 1'b1;
            tick();
            a_if.i_tx_ctrl_valid = 1'b0;
            wait_hdr_a(found);
            checks++; if (found !== 1'b1) begin errors++; $display("FAIL cmd%0d_timeout: no header seen", k); end
            checks++; if (a_if.o_seq_number !== v[k].seq) begin errors++; $display("FAIL cmd%0d_seq: got %h want %h", k, a_if.o_seq_number, v[k].seq); end
            checks++; if (a_if.o_ack_number !== 32'hABCD_0001) begin errors++; $display("FAIL cmd%0d_acknum: got %h want abcd0001", k, a_if.o_ack_number); end
            checks++; if (a_if.o_flags !== v[k].flags) begin errors++; $display("FAIL cmd%0d_flags: got %h want %h", k, a_if.o_flags, v[k].flags); end
            checks++; if (a_if.o_payload_len !== v[k].plen) begin errors++; $display("FAIL cmd%0d_len: got %h want %h", k, a_if.o_payload_len, v[k].plen); end
            checks++; if (a_if.o_window_size !== 16'h0800) begin errors++; $display("FAIL cmd%0d_window: got %h want 0800", k, a_if.o_window_size); end
            tick();
            checks++; if (snd_nxt_a !== v[k].snd) begin errors++; $display("FAIL cmd%0d_snd_nxt: got %h want %h", k, snd_nxt_a, v[k].snd); end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] exp_acks;
        int hs;
        exp_acks = 6'b01_1111;
        a_if.i_hdr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_if.i_tx_ctrl = 3'd3; a_if.i_tx_len = 16'd0; a_if.i_tx_ctrl_valid = 1'b1;
            #1;
            checks++; if (a_if.o_tx_ctrl_ack !== exp_acks[i]) begin errors++; $display("FAIL bp_ack%0d: got %b want %b", i, a_if.o_tx_ctrl_ack, exp_acks[i]); end
            tick();
        end
        a_if.i_tx_ctrl_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_if.o_hdr_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, a_if.o_hdr_valid); end
            checks++; if (a_if.o_seq_number !== 32'h0000_1066) begin errors++; $display("FAIL bp_hold_seq%0d: got %h want 00001066", i, a_if.o_seq_number); end
            checks++; if (a_if.o_flags !== 8'h10) begin errors++; $display("FAIL bp_hold_flags%0d: got %h want 10", i, a_if.o_flags); end
            tick();
        end
        a_if.i_hdr_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 25; i++) begin
            if (a_if.o_hdr_valid === 1'b1) begin
                hs++;
                checks++; if (a_if.o_flags !== 8'h10) begin errors++; $display("FAIL bp_drain_flags%0d: got %h want 10", hs, a_if.o_flags); end
            end
            tick();
        end
        checks++; if (hs !== 5) begin errors++; $display("FAIL bp_header_count: got %0d want 5", hs); end
        checks++; if (snd_nxt_a !== 32'h0000_1066) begin errors++; $display("FAIL bp_snd_nxt: got %h want 00001066", snd_nxt_a); end
    endtask

    task automatic test_reserved();
        bit found;
        int extra;
        a_if.i_hdr_ready = 1'b1;
        a_if.i_tx_ctrl = 3'd7; a_if.i_tx_len = 16'd40; a_if.i_tx_ctrl_valid = 1'b1;
        #1;
        checks++; if (a_if.o_tx_ctrl_ack !== 1'b1) begin errors++; $display("FAIL rsvd_ack: got %b want 1", a_if.o_tx_ctrl_ack); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rsvd_err_early: got %b want 0", err_a); end
        tick();
        a_if.i_tx_ctrl = 3'd5; a_if.i_tx_len = 16'd0;
        checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL rsvd_err_pulse: got %b want 1", err_a); end
        tick();
        a_if.i_tx_ctrl_valid = 1'b0;
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rsvd_err_clear: got %b want 0", err_a); end
        wait_hdr_a(found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_timeout: no header seen"); end
        checks++; if (a_if.o_flags !== 8'h14) begin errors++; $display("FAIL rst_flags: got %h want 14", a_if.o_flags); end
        checks++; if (a_if.o_seq_number !== 32'h0000_1066) begin errors++; $display("FAIL rst_seq: got %h want 00001066", a_if.o_seq_number); end
        tick();
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_if.o_hdr_valid === 1'b1) extra++;
            tick();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL rsvd_extra_headers: got %0d want 0", extra); end
        checks++; if (snd_nxt_a !== 32'h0000_1066) begin errors++; $display("FAIL rst_snd_nxt: got %h want 00001066", snd_nxt_a); end
`ifdef TCP_TX_HDR_STATS_EN
        checks++; if (st_hdrs_a !== 32'd11) begin errors++; $display("FAIL stat_hdrs: got %0d want 11", st_hdrs_a); end
        checks++; if (st_bytes_a !== 32'd100) begin errors++; $display("FAIL stat_bytes: got %0d want 100", st_bytes_a); end
        checks++; if (st_drops_a !== 16'd1) begin errors++; $display("FAIL stat_drops: got %0d want 1", st_drops_a); end
`endif
    endtask

    task automatic test_wrap();
        int hs;
        rcv_nxt_b = 32'h0000_0055; wnd_valid_b = 1'b0; rcv_wnd_b = 16'h1234;
        b_if.i_hdr_ready = 1'b1;
        b_if.i_tx_ctrl = 3'd6; b_if.i_tx_len = 16'h0020; b_if.i_tx_ctrl_valid = 1'b1;
        #1;
        checks++; if (b_if.o_tx_ctrl_ack !== 1'b1) begin errors++; $display("FAIL wrap_ack_data: got %b want 1", b_if.o_tx_ctrl_ack); end
        tick();
        b_if.i_tx_ctrl = 3'd4; b_if.i_tx_len = 16'h0000;
        tick();
        b_if.i_tx_ctrl_valid = 1'b0;
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            if (b_if.o_hdr_valid === 1'b1) begin
                if (hs == 0) begin
                    checks++; if (b_if.o_seq_number !== 32'hFFFF_FFF0) begin errors++; $display("FAIL wrap_data_seq: got %h want fffffff0", b_if.o_seq_number); end
                    checks++; if (b_if.o_payload_len !== 16'h0020) begin errors++; $display("FAIL wrap_data_len: got %h want 0020", b_if.o_payload_len); end
                end else begin
                    checks++; if (b_if.o_seq_number !== 32'h0000_0010) begin errors++; $display("FAIL wrap_fin_seq: got %h want 00000010", b_if.o_seq_number); end
                    checks++; if (b_if.o_flags !== 8'h11) begin errors++; $display("FAIL wrap_fin_flags: got %h want 11", b_if.o_flags); end
                    checks++; if (b_if.o_ack_number !== 32'h0000_0055) begin errors++; $display("FAIL wrap_fin_acknum: got %h want 00000055", b_if.o_ack_number); end
                    checks++; if (b_if.o_window_size !== 16'hFFFF) begin errors++; $display("FAIL wrap_fin_window: got %h want ffff", b_if.o_window_size); end
                end
                hs++;
            end
            tick();
        end
        checks++; if (hs !== 2) begin errors++; $display("FAIL wrap_header_count: got %0d want 2", hs); end
        checks++; if (snd_nxt_b !== 32'h0000_0011) begin errors++; $display("FAIL wrap_snd_nxt: got %h want 00000011", snd_nxt_b); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int extra;
        a_if.i_hdr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_if.i_tx_ctrl = 3'd4; a_if.i_tx_len = 16'd0; a_if.i_tx_ctrl_valid = 1'b1;
            tick();
        end
        a_if.i_tx_ctrl_valid = 1'b0;
        wait_hdr_a(found);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_timeout: no header seen"); end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (a_if.o_hdr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", a_if.o_hdr_valid); end
        checks++; if (snd_nxt_a !== 32'h0000_1000) begin errors++; $display("FAIL mid_snd_nxt: got %h want 00001000", snd_nxt_a); end
        checks++; if (a_if.o_flags !== 8'h00) begin errors++; $display("FAIL mid_flags: got %h want 00", a_if.o_flags); end
`ifdef TCP_TX_HDR_STATS_EN
        checks++; if (st_hdrs_a !== 32'd0) begin errors++; $display("FAIL mid_stat_hdrs: got %0d want 0", st_hdrs_a); end
`endif
        a_if.i_hdr_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (a_if.o_hdr_valid === 1'b1) extra++;
            tick();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL mid_extra_headers: got %0d want 0", extra); end
        checks++; if (snd_nxt_a !== 32'h0000_1000) begin errors++; $display("FAIL mid_snd_nxt_final: got %h want 00001000", snd_nxt_a); end
    endtask

    initial begin
        i_rst = 1'b1;
        a_if.i_tx_ctrl = 3'd0; a_if.i_tx_len = 16'd0; a_if.i_tx_ctrl_valid = 1'b0; a_if.i_hdr_ready = 1'b0;
        b_if.i_tx_ctrl = 3'd0; b_if.i_tx_len = 16'd0; b_if.i_tx_ctrl_valid = 1'b0; b_if.i_hdr_ready = 1'b0;
        rcv_nxt_a = 32'h0; rcv_wnd_a = 16'h0; wnd_valid_a = 1'b0;
        rcv_nxt_b = 32'h0; rcv_wnd_b = 16'h0; wnd_valid_b = 1'b0;
        test_reset();
        test_syn_latency();
        test_commands();
        test_backpressure();
        test_reserved();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
